// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module      : multicycle_control_if
// Description : Control bundle between the multi-cycle MIPS controller
//               (master) and its datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_source;
    logic                illegal_op;
    logic [3:0]          state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, state_dbg
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multi-cycle MIPS datapath; sequences
//               fetch/decode/execute/memory/writeback with memory stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int                  OPCODE_W = 6,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = 6'd0,
    parameter logic [OPCODE_W-1:0] OP_LW    = 6'd35,
    parameter logic [OPCODE_W-1:0] OP_SW    = 6'd43,
    parameter logic [OPCODE_W-1:0] OP_BEQ   = 6'd4,
    parameter logic [OPCODE_W-1:0] OP_BNE   = 6'd5,
    parameter logic [OPCODE_W-1:0] OP_J     = 6'd2,
    parameter logic [OPCODE_W-1:0] OP_ADDI  = 6'd8
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MADDR  = 4'd2,
        MRD    = 4'd3,
        MWB    = 4'd4,
        MWR    = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic w_is_rtype;
    logic w_is_mem;
    logic w_is_branch;
    logic w_is_jump;
    logic w_is_addi;

    assign w_is_rtype  = (bus.opcode == OP_RTYPE);
    assign w_is_mem    = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
    assign w_is_branch = (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE);
    assign w_is_jump   = (bus.opcode == OP_J);
    assign w_is_addi   = (bus.opcode == OP_ADDI);

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (w_is_rtype)       state_d = REXEC;
                else if (w_is_mem)    state_d = MADDR;
                else if (w_is_branch) state_d = BRANCH;
                else if (w_is_jump)   state_d = JUMP;
                else if (w_is_addi)   state_d = IEXEC;
                else                  state_d = FETCH;
            end
            // Only LW/SW can reach MADDR because the IR holds the opcode.
            MADDR: begin
                if (bus.opcode == OP_LW)      state_d = MRD;
                else if (bus.opcode == OP_SW) state_d = MWR;
                else                          state_d = FETCH;
            end
            MRD:     state_d = bus.mem_ready ? MWB : MRD;
            MWB:     state_d = FETCH;
            MWR:     state_d = bus.mem_ready ? FETCH : MWR;
            REXEC:   state_d = RWB;
            RWB:     state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            IEXEC:   state_d = IWB;
            IWB:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.illegal_op    = 1'b0;
        case (state_q)
            FETCH: begin
                // PC+4 is computed every fetch cycle; committed only when memory answers.
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b  = 2'b11;
                bus.illegal_op = !(w_is_rtype || w_is_mem || w_is_branch ||
                                   w_is_jump || w_is_addi);
            end
            MADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            MWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            REXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                bus.branch_ne     = (bus.opcode == OP_BNE);
            end
            JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            IEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            IWB: begin
                bus.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state_dbg = state_q;

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised successor to the single-cycle opcode decoder. It is the main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several clocks, and stalls on a memory-ready handshake. It adds BNE, J and ADDI support and illegal-opcode detection, and drives every datapath mux and enable.

Parameters:
OPCODE_W, 6, opcode field width (instruction bits 31:26)
OP_RTYPE, 6'd0, R-format opcode
OP_LW, 6'd35, load word opcode
OP_SW, 6'd43, store word opcode
OP_BEQ, 6'd4, branch-if-equal opcode
OP_BNE, 6'd5, branch-if-not-equal opcode
OP_J, 6'd2, jump opcode
OP_ADDI, 6'd8, add-immediate opcode

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  conditional PC load (datapath gates it with zero XOR branch_ne)
branch_ne  out  1  inverts the branch condition (BNE)
iord  out  1  0 = memory address from PC, 1 = from ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
reg_dst  out  1  destination register: 0 = rt, 1 = rd
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
alu_src_b  out  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct field
pc_source  out  2  PC input: 00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse in DECODE when opcode matches no parameter
state_dbg  out  4  current state encoding

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- reset forces state = FETCH (4'd0) immediately. Reset mid-instruction aborts it; no partial writeback follows.
- All outputs are combinational from state. Only ir_write, pc_write and the memory-state exits also qualify on mem_ready. Any output not listed for a state is 0.
- Value of every output while held in reset (FETCH): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready; all other outputs 0; state_dbg=0.
- States and outputs:
  - FETCH(0): outputs as above. Stay while !mem_ready; else go to DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - R-type -> REXEC
    - LW or SW -> MADDR
    - BEQ or BNE -> BRANCH
    - J -> JUMP
    - ADDI -> IEXEC
    - otherwise: illegal_op=1, go to FETCH.
  - MADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MRD; SW -> MWR.
  - MRD(3): mem_read=1, iord=1. Stay while !mem_ready; else go to MWB.
  - MWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MWR(5): mem_write=1, iord=1. Stay while !mem_ready; else go to FETCH.
  - REXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
  - RWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==OP_BNE). Go to FETCH.
  - JUMP(9): pc_write=1, pc_source=10. Go to FETCH.
  - IEXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00. Go to IWB.
  - IWB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
  - Encodings 12–15 are unreachable; if entered, go to FETCH with all outputs 0.
- Latency with mem_ready held at 1:
  - LW: 5 cycles
  - R-type, SW, ADDI: 4 cycles
  - BEQ, BNE, J: 3 cycles
  - Each cycle with mem_ready=0 in FETCH, MRD or MWR adds one cycle.
- mem_read and mem_write are never both 1. reg_write and pc_write are never both 1.
- opcode is sampled only in DECODE, MADDR and BRANCH. The IR holds it stable from the cycle after FETCH completes.

Test Plan:
- reset=1 asserted mid-MRD with no clk edge -> state_dbg=0, mem_read=1, iord=0, reg_write=0 immediately; after release, normal fetch resumes.
- opcode=0, mem_ready=1 -> state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in cycle 4; alu_op=10 in cycle 3.
- opcode=35, mem_ready low for 2 cycles in MRD -> sequence 0,1,2,3,3,3,4,0; mem_to_reg=1 and reg_write=1 in state 4 only.
- opcode=43 -> sequence 0,1,2,5,0; mem_write=1 and iord=1 in state 5; reg_write never 1.
- opcode=4, then opcode=5 -> state 8 with pc_write_cond=1, pc_source=01, alu_op=01; branch_ne=0 for BEQ, 1 for BNE.
- opcode=6'h3F -> illegal_op=1 for exactly one cycle in state 1, next state 0, no write enables asserted. opcode=2 -> state 9 with pc_write=1, pc_source=10.
